// File: rtl/seq_matrix_multiplier.sv
// Sequential NxN signed fixed-point matrix multiplier: one MAC unit time-multiplexed over N^3 cycles.
// Valid/ready on both sides; each element is accumulated at full precision, then rounded/saturated once.
module seq_matrix_multiplier #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ROUND  = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*N-1:0][DATA_W-1:0]   matA,
  input  logic [N*N-1:0][DATA_W-1:0]   matB,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*N-1:0][DATA_W-1:0]   res_mat,
  output logic                         overflow
);

  localparam int IDX_W  = $clog2(N);
  localparam int EL_W   = $clog2(N*N);
  localparam int PROD_W = 2*DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(N);
  localparam int EXT_W  = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] RND_C =
    (ROUND != 0) ? (EXT_W'(1) << (FRAC_W-1)) : '0;
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [N*N-1:0][DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [N*N-1:0][DATA_W-1:0]   res_q, res_d;
  logic [IDX_W-1:0]             i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic                         ovf_q, ovf_d;

  logic [EL_W-1:0]              a_idx, b_idx, r_idx;
  logic signed [DATA_W-1:0]     a_el, b_el;
  logic signed [PROD_W-1:0]     prod;
  logic signed [EXT_W-1:0]      sum_ext, rnd_sum, shifted;
  logic [DATA_W-1:0]            sat_val;
  logic                         clamp;
  logic                         last_k, last_j, last_i;

  // MAC datapath: k runs fastest, so A walks a row while B walks a column.
  always_comb begin
    a_idx   = EL_W'(i_q) * EL_W'(N) + EL_W'(k_q);
    b_idx   = EL_W'(k_q) * EL_W'(N) + EL_W'(j_q);
    r_idx   = EL_W'(i_q) * EL_W'(N) + EL_W'(j_q);
    a_el    = signed'(a_q[a_idx]);
    b_el    = signed'(b_q[b_idx]);
    prod    = a_el * b_el;
    sum_ext = {acc_q[ACC_W-1], acc_q} + {{(EXT_W-PROD_W){prod[PROD_W-1]}}, prod};
    rnd_sum = sum_ext + RND_C;
    shifted = rnd_sum >>> FRAC_W;
    clamp   = 1'b0;
    sat_val = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
      clamp   = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val = {1'b1, {(DATA_W-1){1'b0}}};
      clamp   = 1'b1;
    end
    last_k = (k_q == IDX_W'(N-1));
    last_j = (j_q == IDX_W'(N-1));
    last_i = (i_q == IDX_W'(N-1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = matA;
          b_d     = matB;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (last_k) begin
          res_d[r_idx] = sat_val;
          ovf_d        = ovf_q | clamp;
          acc_d        = '0;
          k_d          = '0;
          if (last_j) begin
            j_d = '0;
            if (last_i) begin
              i_d     = '0;
              state_d = S_DONE;
            end else begin
              i_d = i_q + IDX_W'(1);
            end
          end else begin
            j_d = j_q + IDX_W'(1);
          end
        end else begin
          // Accumulator is wide enough that N full products never wrap.
          acc_d = sum_ext[ACC_W-1:0];
          k_d   = k_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res_mat   = res_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// Randomised and directed bench for seq_matrix_multiplier with a scoreboard fed by a
// behavioural matrix-product model; a separate monitor pops and checks every released result.
`timescale 1ns/1ps
module tb_seq_matrix_multiplier;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int FW  = 8;
  localparam int RND = 1;
  localparam int LAT = N*N*N;

  typedef logic [N*N-1:0][DW-1:0] mat_t;
  typedef struct {
    mat_t m;
    bit   ovf;
    int   acc_cyc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b1;
  logic overflow;
  mat_t matA = '0;
  mat_t matB = '0;
  mat_t res_mat;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;
  int   rise_cyc = 0;
  bit   prev_vld = 1'b0;
  exp_t sb[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  seq_matrix_multiplier #(.N(N), .DATA_W(DW), .FRAC_W(FW), .ROUND(RND)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .matA(matA), .matB(matB),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_mat(res_mat), .overflow(overflow)
  );

  task automatic chk(input bit ok, input string name, input string act, input string req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  // Plain integer matrix product, then fixed-point rescale and clamp per element.
  function automatic exp_t model(input mat_t a, input mat_t b);
    exp_t   e;
    longint s;
    longint maxv = (64'sd1 <<< (DW-1)) - 1;
    longint minv = -(64'sd1 <<< (DW-1));
    e.ovf = 1'b0;
    e.acc_cyc = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += longint'($signed(a[r*N+k])) * longint'($signed(b[k*N+c]));
        if (RND != 0) s += (64'sd1 <<< (FW-1));
        s = s >>> FW;
        if (s > maxv) begin s = maxv; e.ovf = 1'b1; end
        if (s < minv) begin s = minv; e.ovf = 1'b1; end
        e.m[r*N+c] = DW'(s);
      end
    end
    return e;
  endfunction

  function automatic mat_t rnd_mat(input int lim);
    mat_t m;
    for (int e = 0; e < N*N; e++) begin
      if (lim <= 0) m[e] = DW'($urandom());
      else m[e] = DW'(int'($urandom_range(2*lim, 0)) - lim);
    end
    return m;
  endfunction

  function automatic mat_t fill(input logic [DW-1:0] v);
    mat_t m;
    for (int e = 0; e < N*N; e++) m[e] = v;
    return m;
  endfunction

  function automatic mat_t diag(input logic [DW-1:0] v);
    mat_t m = '0;
    for (int r = 0; r < N; r++) m[r*N+r] = v;
    return m;
  endfunction

  // Callers sit just after a rising edge.
  task automatic issue(input mat_t a, input mat_t b, input bit push);
    exp_t e;
    int   g = 0;
    while (!in_ready && g < 300) begin
      @(posedge Clk); #1;
      g++;
    end
    if (!in_ready) begin
      chk(1'b0, "accept_timeout", "in_ready=0", "in_ready=1");
      return;
    end
    matA = a; matB = b; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    matA = ~a; matB = ~b;
    if (push) begin
      e = model(a, b);
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_out(input int target);
    int g = 0;
    while (n_out < target && g < LAT + 100) begin
      @(posedge Clk);
      g++;
    end
    #1;
    if (n_out < target) chk(1'b0, "result_timeout", "no out_valid", "result released");
  endtask

  task automatic run(input mat_t a, input mat_t b);
    int t = n_out + 1;
    issue(a, b, 1'b1);
    wait_out(t);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_vld = 1'b0;
      end else begin
        if (out_valid && !prev_vld) rise_cyc = cyc;
        prev_vld = out_valid;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_result", "out_valid=1", "no pending operands");
          end else begin
            e = sb.pop_front();
            chk(res_mat == e.m, "res_mat", $sformatf("%h", res_mat), $sformatf("%h", e.m));
            chk(overflow == e.ovf, "overflow", $sformatf("%0b", overflow), $sformatf("%0b", e.ovf));
            chk(rise_cyc - e.acc_cyc == LAT, "latency",
                $sformatf("%0d", rise_cyc - e.acc_cyc), $sformatf("%0d", LAT));
          end
          n_out++;
        end
      end
    end
  end

  initial begin : stim
    mat_t a, b;
    exp_t e_bp;
    int   t, g;

    #1;
    chk(out_valid == 1'b0 && overflow == 1'b0, "reset_flags",
        $sformatf("vld=%0b ovf=%0b", out_valid, overflow), "vld=0 ovf=0");
    chk(res_mat == '0, "reset_res", $sformatf("%h", res_mat), "all zero");
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk(in_ready == 1'b1, "reset_in_ready", $sformatf("%0b", in_ready), "1");
    @(posedge Clk); #1;

    run(diag(16'h0100), rnd_mat(4000));
    run(diag(16'hFE00), fill(16'h0180));
    run(fill(16'h7FFF), fill(16'h7FFF));
    run(fill(16'h8000), fill(16'h7FFF));
    run(rnd_mat(512), rnd_mat(512));

    a = '0; b = '0;
    a[0] = 16'h0001; b[0] = 16'h0080;
    run(a, b);

    for (int n = 0; n < 6; n++) run(rnd_mat(1024), rnd_mat(1024));
    for (int n = 0; n < 3; n++) run(rnd_mat(0), rnd_mat(0));

    // Backpressure: result must hold while the consumer stalls; new operands ignored.
    a = rnd_mat(2000); b = rnd_mat(2000);
    e_bp = model(a, b);
    out_ready = 1'b0;
    t = n_out + 1;
    issue(a, b, 1'b1);
    g = 0;
    while (!out_valid && g < LAT + 50) begin
      @(negedge Clk);
      g++;
    end
    if (!out_valid) chk(1'b0, "bp_timeout", "out_valid=0", "out_valid=1");
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      in_valid = c[0];
      matA = rnd_mat(0); matB = rnd_mat(0);
      @(negedge Clk);
      chk(out_valid && !in_ready && res_mat == e_bp.m && overflow == e_bp.ovf, "bp_hold",
          $sformatf("vld=%0b rdy=%0b ovf=%0b res=%h", out_valid, in_ready, overflow, res_mat),
          $sformatf("vld=1 rdy=0 ovf=%0b res=%h", e_bp.ovf, e_bp.m));
    end
    @(posedge Clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_out(t);
    @(negedge Clk);
    chk(!out_valid && in_ready, "bp_release",
        $sformatf("vld=%0b rdy=%0b", out_valid, in_ready), "vld=0 rdy=1");
    @(negedge Clk);
    chk(in_ready == 1'b1, "bp_no_capture", $sformatf("%0b", in_ready), "1");
    @(posedge Clk); #1;

    // Reset mid-calculation discards the pending result.
    issue(rnd_mat(1000), rnd_mat(1000), 1'b0);
    repeat (20) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    chk(!out_valid && !overflow && res_mat == '0, "midcalc_reset",
        $sformatf("vld=%0b ovf=%0b res=%h", out_valid, overflow, res_mat), "vld=0 ovf=0 res=0");
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    chk(in_ready && !out_valid, "post_reset_idle",
        $sformatf("rdy=%0b vld=%0b", in_ready, out_valid), "rdy=1 vld=0");
    @(posedge Clk); #1;
    run(rnd_mat(1500), rnd_mat(1500));
    run(diag(16'h0100), fill(16'hFF80));

    repeat (5) @(posedge Clk);
    chk(sb.size() == 0, "scoreboard_drained", $sformatf("%0d pending", sb.size()), "0 pending");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_matrix_multiplier.md
Name: seq_matrix_multiplier

Overview:
Parametrised, sequential NxN signed fixed-point matrix multiplier that computes res = A x B. It uses one multiply-accumulate unit, time-multiplexed over N^3 cycles, with valid/ready handshakes on input and output. Each element is accumulated at full precision and then rounded and saturated once. It feeds the transform stage (model/view/projection concatenation) of the 3D pipeline and replaces the 16-parallel-dot-product combinational multiplier, giving much lower area at a fixed latency.

Parameters:
N, 4, matrix dimension (N >= 2); matrices are row-major, index = row*N + col
DATA_W, 16, signed two's-complement element width
FRAC_W, 8, fractional bits, giving Q(DATA_W-FRAC_W).FRAC_W format; 1 <= FRAC_W < DATA_W
ROUND, 1, 1 = round-half-up before the shift; 0 = truncate (arithmetic shift, floor)

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
in_valid  in  1  matA/matB valid
in_ready  out  1  block can accept operands
matA  in  [N*N-1:0][DATA_W-1:0]  left operand, row-major
matB  in  [N*N-1:0][DATA_W-1:0]  right operand, row-major
out_valid  out  1  res_mat/overflow valid
out_ready  in  1  consumer accepts result
res_mat  out  [N*N-1:0][DATA_W-1:0]  product, row-major, registered
overflow  out  1  at least one element of the current result saturated

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; counters i,j,k=0; accumulator=0; res_mat all 0; out_valid=0; overflow=0. in_ready=1 once Reset deasserts.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1, register matA and matB internally, clear the accumulator, i=j=k=0, clear overflow, go to CALC. The inputs may change after acceptance.
  - CALC: in_ready=0, out_valid=0. Each cycle: acc += Aq[i*N+k] * Bq[k*N+j] (signed full product).
    - k counts fastest, then j, then i.
    - When k==N-1, on the same edge: res_mat[i*N+j] is written with scale(acc + product); acc is cleared; k wraps to 0; (i,j) advances.
    - After element (N-1,N-1) is written, go to DONE.
  - DONE: out_valid=1, in_ready=0. res_mat and overflow are held stable. On an edge with out_ready=1, go to IDLE; out_valid drops the next cycle.
- Latency: acceptance edge, then exactly N^3 CALC cycles. out_valid is high N^3 cycles after the acceptance edge (64 for N=4).
- Throughput: one matrix per N^3+2 cycles minimum. No new operand is accepted in the same cycle a result is released.
- Arithmetic:
  - Accumulator width = 2*DATA_W + clog2(N), so there is no internal overflow.
  - scale(x): if ROUND=1, x += 2^(FRAC_W-1); then arithmetic shift right by FRAC_W.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp sets the sticky overflow for the current matrix.
- res_mat contents outside DONE are undefined to consumers; partial results are visible during CALC.
- Reset asserted mid-CALC or mid-DONE aborts immediately to the reset state; the pending result is discarded and no out_valid is issued.
- in_valid outside IDLE is ignored and the operands are not captured. out_ready outside DONE is ignored.

Test Plan:
- Identity (N=4, Q8.8): A = diag(0x0100), B = arbitrary values incl. negatives -> res_mat==B, overflow=0, out_valid exactly 64 cycles after acceptance.
- Scale and sign: A = diag(0xFE00) (-2.0), B[all] = 0x0180 (1.5) -> every element 0xFD00 (-3.0), overflow=0.
- Saturation: A, B all 0x7FFF -> all elements 0x7FFF, overflow=1. Repeat with A all 0x8000, B all 0x7FFF -> all elements 0x8000, overflow=1. A following in-range matrix -> overflow=0.
- Rounding: A[0]=0x0001, B[0]=0x0080, other elements 0 -> res_mat[0]=0x0001 with ROUND=1, 0x0000 with ROUND=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, res_mat and overflow stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Reset mid-CALC at cycle 20 -> out_valid=0, res_mat all 0, in_ready=1. A new operand pair then completes correctly in 64 cycles.
